// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage.
// ALU results pass straight to writeback one cycle after acceptance. Loads and
// stores hold the stage in BUSY, stalling upstream, until the memory completes.
// Optional feature macro: MEM_TIMEOUT_EN. When it is defined, a BUSY access
// that sees no mem_ready for TIMEOUT_CYCLES cycles is aborted and mem_fault
// pulses. When it is undefined, BUSY waits forever and mem_fault is tied low.
//
// state | meaning
// IDLE  | accepting ex_* every cycle; ALU ops retire with latency 1
// BUSY  | memory request outstanding; ex_* ignored, stall high
module mem_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [32:0] ex_result,
  input  logic [31:0] ex_store_data,
  input  logic        ex_is_load,
  input  logic        ex_is_store,
  input  logic [2:0]  ex_dest_reg,
  input  logic [3:0]  ex_flags,
  input  logic        ex_flags_we,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        wb_valid,
  output logic [2:0]  wb_dest_reg,
  output logic [31:0] wb_data,
  output logic        wb_reg_we,
  output logic [3:0]  cpsr,
  output logic        mem_fault
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  logic [0:0]  state_q, state_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        pend_load_q, pend_load_d;
  logic [2:0]  pend_dest_q, pend_dest_d;
  logic        wb_valid_q, wb_valid_d;
  logic [2:0]  wb_dest_reg_q, wb_dest_reg_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        wb_reg_we_q, wb_reg_we_d;
  logic [3:0]  cpsr_q, cpsr_d;

  logic accept;
  logic is_mem;
  logic abort;

  // Bit 32 of the execute result carries nothing this stage needs.
  logic unused_ex_bits;
  assign unused_ex_bits = ex_result[32];

  assign accept = (state_q == ST_IDLE) && ex_valid;
  assign is_mem = ex_is_load || ex_is_store;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned     CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             mem_fault_q, mem_fault_d;

  // A late mem_ready on the terminal cycle still completes normally.
  assign abort = (state_q == ST_BUSY) && !mem_ready && (tmo_cnt_q == '0);

  // Down-counter reloaded on every memory accept; terminal count is zero.
  always_comb begin
    tmo_cnt_d   = tmo_cnt_q;
    mem_fault_d = abort;
    if (accept && is_mem) begin
      tmo_cnt_d = CNT_LOAD;
    end else if ((state_q == ST_BUSY) && (tmo_cnt_q != '0)) begin
      tmo_cnt_d = tmo_cnt_q - CNT_W'(1);
    end
  end

  // Timeout counter and fault pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt_q   <= '0;
      mem_fault_q <= 1'b0;
    end else begin
      tmo_cnt_q   <= tmo_cnt_d;
      mem_fault_q <= mem_fault_d;
    end
  end

  assign mem_fault = mem_fault_q;
`else
  assign abort     = 1'b0;
  assign mem_fault = 1'b0;
`endif

  // Next-state, memory request and writeback decisions.
  always_comb begin
    state_d       = state_q;
    mem_req_d     = mem_req_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    pend_load_d   = pend_load_q;
    pend_dest_d   = pend_dest_q;
    wb_valid_d    = 1'b0;
    wb_dest_reg_d = wb_dest_reg_q;
    wb_data_d     = wb_data_q;
    wb_reg_we_d   = wb_reg_we_q;
    cpsr_d        = cpsr_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (ex_flags_we) begin
            cpsr_d = ex_flags;
          end
          if (is_mem) begin
            state_d     = ST_BUSY;
            mem_req_d   = 1'b1;
            // Load wins when both load and store are flagged.
            mem_we_d    = ex_is_store && !ex_is_load;
            mem_addr_d  = ex_result[31:0];
            mem_wdata_d = ex_store_data;
            pend_load_d = ex_is_load;
            pend_dest_d = ex_dest_reg;
          end else begin
            wb_valid_d    = 1'b1;
            wb_reg_we_d   = 1'b1;
            wb_data_d     = ex_result[31:0];
            wb_dest_reg_d = ex_dest_reg;
          end
        end
      end
      default: begin
        if (mem_ready || abort) begin
          state_d       = ST_IDLE;
          mem_req_d     = 1'b0;
          wb_valid_d    = 1'b1;
          wb_dest_reg_d = pend_dest_q;
          if (mem_ready && pend_load_q) begin
            wb_reg_we_d = 1'b1;
            wb_data_d   = mem_rdata;
          end else begin
            wb_reg_we_d = 1'b0;
            wb_data_d   = 32'h0;
          end
        end
      end
    endcase
  end

  // Stage registers; reset drops an outstanding request immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= 32'h0;
      mem_wdata_q   <= 32'h0;
      pend_load_q   <= 1'b0;
      pend_dest_q   <= 3'h0;
      wb_valid_q    <= 1'b0;
      wb_dest_reg_q <= 3'h0;
      wb_data_q     <= 32'h0;
      wb_reg_we_q   <= 1'b0;
      cpsr_q        <= 4'h0;
    end else begin
      state_q       <= state_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      pend_load_q   <= pend_load_d;
      pend_dest_q   <= pend_dest_d;
      wb_valid_q    <= wb_valid_d;
      wb_dest_reg_q <= wb_dest_reg_d;
      wb_data_q     <= wb_data_d;
      wb_reg_we_q   <= wb_reg_we_d;
      cpsr_q        <= cpsr_d;
    end
  end

  assign stall       = (state_q == ST_BUSY);
  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign wb_valid    = wb_valid_q;
  assign wb_dest_reg = wb_dest_reg_q;
  assign wb_data     = wb_data_q;
  assign wb_reg_we   = wb_reg_we_q;
  assign cpsr        = cpsr_q;

endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage: directed scenarios plus a randomized instruction
// stream checked against a transaction-level model of the stage.
module tb_mem_stage;

  logic        clk;
  logic        rst;
  logic        ex_valid;
  logic [32:0] ex_result;
  logic [31:0] ex_store_data;
  logic        ex_is_load;
  logic        ex_is_store;
  logic [2:0]  ex_dest_reg;
  logic [3:0]  ex_flags;
  logic        ex_flags_we;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        wb_valid;
  logic [2:0]  wb_dest_reg;
  logic [31:0] wb_data;
  logic        wb_reg_we;
  logic [3:0]  cpsr;
  logic        mem_fault;

  int errors = 0;
  int checks = 0;

  // Model state: architectural flags and last writeback value.
  logic [3:0]  exp_cpsr;
  logic [31:0] exp_wb_data;

  mem_stage #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_result(ex_result), .ex_store_data(ex_store_data),
    .ex_is_load(ex_is_load), .ex_is_store(ex_is_store), .ex_dest_reg(ex_dest_reg),
    .ex_flags(ex_flags), .ex_flags_we(ex_flags_we),
    .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_dest_reg(wb_dest_reg), .wb_data(wb_data),
    .wb_reg_we(wb_reg_we), .cpsr(cpsr), .mem_fault(mem_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_none;
    ex_valid      = 1'b0;
    ex_result     = 33'h0;
    ex_store_data = 32'h0;
    ex_is_load    = 1'b0;
    ex_is_store   = 1'b0;
    ex_dest_reg   = 3'h0;
    ex_flags      = 4'h0;
    ex_flags_we   = 1'b0;
    mem_ready     = 1'b0;
    mem_rdata     = 32'h0;
  endtask

  task automatic drive_junk;
    ex_valid      = 1'b1;
    ex_result     = {1'b1, $urandom};
    ex_store_data = $urandom;
    ex_is_load    = $urandom_range(0, 1) == 1;
    ex_is_store   = $urandom_range(0, 1) == 1;
    ex_dest_reg   = 3'($urandom_range(0, 7));
    ex_flags      = 4'($urandom_range(0, 15));
    ex_flags_we   = 1'b1;
  endtask

  task automatic test_reset;
    drive_none();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({stall, mem_req, mem_we, mem_addr, mem_wdata, wb_valid, wb_reg_we, wb_data,
         wb_dest_reg, cpsr, mem_fault} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: stall=%b req=%b we=%b addr=%h wdata=%h wbv=%b wbwe=%b wbd=%h dst=%0d cpsr=%h flt=%b, required all zero",
               stall, mem_req, mem_we, mem_addr, mem_wdata, wb_valid, wb_reg_we, wb_data,
               wb_dest_reg, cpsr, mem_fault);
    end
    rst = 1'b0;
    tick();
    exp_cpsr    = 4'h0;
    exp_wb_data = 32'h0;
  endtask

  task automatic test_alu;
    drive_none();
    ex_valid    = 1'b1;
    ex_result   = 33'h1_0000_0005;
    ex_dest_reg = 3'd3;
    ex_flags    = 4'b0010;
    ex_flags_we = 1'b1;
    mem_ready   = 1'b1;
    tick();
    exp_cpsr    = 4'b0010;
    exp_wb_data = 32'h5;
    checks++;
    if (wb_valid !== 1'b1 || wb_data !== 32'h5 || wb_dest_reg !== 3'd3 || wb_reg_we !== 1'b1 ||
        cpsr !== 4'b0010 || stall !== 1'b0) begin
      errors++;
      $display("FAIL alu_add: wbv=%b data=%h dst=%0d we=%b cpsr=%b stall=%b, required 1 00000005 3 1 0010 0",
               wb_valid, wb_data, wb_dest_reg, wb_reg_we, cpsr, stall);
    end
    drive_none();
    tick();
    checks++;
    if (wb_valid !== 1'b0 || wb_data !== 32'h5 || cpsr !== 4'b0010) begin
      errors++;
      $display("FAIL alu_hold: wbv=%b data=%h cpsr=%b, required 0 00000005 0010", wb_valid, wb_data, cpsr);
    end
  endtask

  task automatic test_load;
    drive_none();
    ex_valid    = 1'b1;
    ex_result   = 33'h0_0000_0100;
    ex_is_load  = 1'b1;
    ex_dest_reg = 3'd6;
    tick();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (stall !== 1'b1 || mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h100 || wb_valid !== 1'b0) begin
        errors++;
        $display("FAIL load_busy[%0d]: stall=%b req=%b we=%b addr=%h wbv=%b, required 1 1 0 00000100 0",
                 i, stall, mem_req, mem_we, mem_addr, wb_valid);
      end
      drive_junk();
      mem_ready = (i == 2);
      mem_rdata = (i == 2) ? 32'hDEAD_BEEF : $urandom;
      tick();
    end
    exp_wb_data = 32'hDEAD_BEEF;
    checks++;
    if (wb_valid !== 1'b1 || wb_data !== 32'hDEAD_BEEF || wb_reg_we !== 1'b1 || wb_dest_reg !== 3'd6 ||
        stall !== 1'b0 || mem_req !== 1'b0 || cpsr !== exp_cpsr) begin
      errors++;
      $display("FAIL load_done: wbv=%b data=%h we=%b dst=%0d stall=%b req=%b cpsr=%b, required 1 deadbeef 1 6 0 0 %b",
               wb_valid, wb_data, wb_reg_we, wb_dest_reg, stall, mem_req, cpsr, exp_cpsr);
    end
    drive_none();
    tick();
  endtask

  task automatic test_store;
    drive_none();
    ex_valid      = 1'b1;
    ex_result     = 33'h0_0000_0040;
    ex_store_data = 32'h1234;
    ex_is_store   = 1'b1;
    tick();
    checks++;
    if (stall !== 1'b1 || mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h40 || mem_wdata !== 32'h1234) begin
      errors++;
      $display("FAIL store_req: stall=%b req=%b we=%b addr=%h wdata=%h, required 1 1 1 00000040 00001234",
               stall, mem_req, mem_we, mem_addr, mem_wdata);
    end
    drive_none();
    mem_ready = 1'b1;
    mem_rdata = 32'hFFFF_FFFF;
    tick();
    exp_wb_data = 32'h0;
    checks++;
    if (wb_valid !== 1'b1 || wb_reg_we !== 1'b0 || wb_data !== 32'h0 || stall !== 1'b0 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL store_done: wbv=%b we=%b data=%h stall=%b req=%b, required 1 0 00000000 0 0",
               wb_valid, wb_reg_we, wb_data, stall, mem_req);
    end
    drive_none();
    tick();
  endtask

  task automatic test_reset_mid_busy;
    drive_none();
    ex_valid    = 1'b1;
    ex_result   = 33'h0_0000_0200;
    ex_is_load  = 1'b1;
    ex_flags    = 4'b1001;
    ex_flags_we = 1'b1;
    tick();
    drive_none();
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if (mem_req !== 1'b0 || stall !== 1'b0 || cpsr !== 4'h0) begin
      errors++;
      $display("FAIL rst_busy_async: req=%b stall=%b cpsr=%b, required 0 0 0000", mem_req, stall, cpsr);
    end
    mem_ready = 1'b1;
    mem_rdata = 32'hAAAA_5555;
    tick();
    checks++;
    if (wb_valid !== 1'b0 || wb_data !== 32'h0) begin
      errors++;
      $display("FAIL rst_busy_no_wb: wbv=%b data=%h, required 0 00000000", wb_valid, wb_data);
    end
    rst = 1'b0;
    exp_cpsr    = 4'h0;
    exp_wb_data = 32'h0;
    drive_none();
    tick();
    ex_valid    = 1'b1;
    ex_result   = 33'h0_0000_0300;
    ex_is_load  = 1'b1;
    ex_dest_reg = 3'd2;
    tick();
    checks++;
    if (stall !== 1'b1 || mem_req !== 1'b1 || mem_addr !== 32'h300) begin
      errors++;
      $display("FAIL rst_next_req: stall=%b req=%b addr=%h, required 1 1 00000300", stall, mem_req, mem_addr);
    end
    drive_none();
    mem_ready = 1'b1;
    mem_rdata = 32'h0BAD_F00D;
    tick();
    exp_wb_data = 32'h0BAD_F00D;
    checks++;
    if (wb_valid !== 1'b1 || wb_data !== 32'h0BAD_F00D || wb_reg_we !== 1'b1 || wb_dest_reg !== 3'd2) begin
      errors++;
      $display("FAIL rst_next_done: wbv=%b data=%h we=%b dst=%0d, required 1 0badf00d 1 2",
               wb_valid, wb_data, wb_reg_we, wb_dest_reg);
    end
    drive_none();
    tick();
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout;
    // First access never answered; second answered on the terminal cycle.
    for (int pass = 0; pass < 2; pass++) begin
      drive_none();
      ex_valid    = 1'b1;
      ex_result   = 33'h0_0000_0500;
      ex_is_load  = 1'b1;
      ex_dest_reg = 3'd5;
      tick();
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (stall !== 1'b1 || mem_req !== 1'b1 || mem_fault !== 1'b0) begin
          errors++;
          $display("FAIL tmo_busy[%0d/%0d]: stall=%b req=%b fault=%b, required 1 1 0", pass, i, stall, mem_req, mem_fault);
        end
        drive_junk();
        mem_ready = (pass == 1) && (i == 15);
        mem_rdata = 32'h7777_1111;
        tick();
      end
      checks++;
      if (pass == 0) begin
        exp_wb_data = 32'h0;
        if (mem_fault !== 1'b1 || wb_valid !== 1'b1 || wb_reg_we !== 1'b0 || stall !== 1'b0 || mem_req !== 1'b0) begin
          errors++;
          $display("FAIL tmo_abort: fault=%b wbv=%b we=%b stall=%b req=%b, required 1 1 0 0 0",
                   mem_fault, wb_valid, wb_reg_we, stall, mem_req);
        end
      end else begin
        exp_wb_data = 32'h7777_1111;
        if (mem_fault !== 1'b0 || wb_valid !== 1'b1 || wb_reg_we !== 1'b1 || wb_data !== 32'h7777_1111 || stall !== 1'b0) begin
          errors++;
          $display("FAIL tmo_ready_wins: fault=%b wbv=%b we=%b data=%h stall=%b, required 0 1 1 77771111 0",
                   mem_fault, wb_valid, wb_reg_we, wb_data, stall);
        end
      end
      drive_none();
      tick();
      checks++;
      if (mem_fault !== 1'b0 || wb_valid !== 1'b0) begin
        errors++;
        $display("FAIL tmo_pulse_end[%0d]: fault=%b wbv=%b, required 0 0", pass, mem_fault, wb_valid);
      end
    end
  endtask
`else
  task automatic test_long_wait;
    drive_none();
    ex_valid    = 1'b1;
    ex_result   = 33'h0_0000_0600;
    ex_is_load  = 1'b1;
    ex_dest_reg = 3'd1;
    tick();
    drive_none();
    for (int i = 0; i < 24; i++) tick();
    checks++;
    if (stall !== 1'b1 || mem_req !== 1'b1 || mem_fault !== 1'b0 || wb_valid !== 1'b0) begin
      errors++;
      $display("FAIL long_wait: stall=%b req=%b fault=%b wbv=%b, required 1 1 0 0", stall, mem_req, mem_fault, wb_valid);
    end
    mem_ready = 1'b1;
    mem_rdata = 32'h1357_2468;
    tick();
    exp_wb_data = 32'h1357_2468;
    checks++;
    if (wb_valid !== 1'b1 || wb_data !== 32'h1357_2468 || wb_reg_we !== 1'b1 || mem_fault !== 1'b0) begin
      errors++;
      $display("FAIL long_wait_done: wbv=%b data=%h we=%b fault=%b, required 1 13572468 1 0",
               wb_valid, wb_data, wb_reg_we, mem_fault);
    end
    drive_none();
    tick();
  endtask
`endif

  // Random instruction stream; kind 0=ALU 1=load 2=store 3=load+store.
  task automatic test_random;
    for (int n = 0; n < 60; n++) begin
      int          kind;
      int          delay;
      bit          is_ld;
      logic [32:0] res;
      logic [31:0] sdata;
      logic [31:0] rdata;
      logic [2:0]  dst;
      logic [3:0]  fl;
      bit          fwe;
      kind  = $urandom_range(0, 3);
      res   = {1'($urandom_range(0, 1)), $urandom};
      sdata = $urandom;
      rdata = $urandom;
      dst   = 3'($urandom_range(0, 7));
      fl    = 4'($urandom_range(0, 15));
      fwe   = $urandom_range(0, 1) == 1;
      is_ld = (kind == 1) || (kind == 3);
      ex_valid      = 1'b1;
      ex_result     = res;
      ex_store_data = sdata;
      ex_is_load    = (kind == 1) || (kind == 3);
      ex_is_store   = (kind == 2) || (kind == 3);
      ex_dest_reg   = dst;
      ex_flags      = fl;
      ex_flags_we   = fwe;
      mem_ready     = $urandom_range(0, 1) == 1;
      mem_rdata     = $urandom;
      tick();
      if (fwe) exp_cpsr = fl;
      if (kind == 0) begin
        exp_wb_data = res[31:0];
        checks++;
        if (wb_valid !== 1'b1 || wb_data !== exp_wb_data || wb_dest_reg !== dst || wb_reg_we !== 1'b1 ||
            cpsr !== exp_cpsr || stall !== 1'b0) begin
          errors++;
          $display("FAIL rnd_alu[%0d]: wbv=%b data=%h dst=%0d we=%b cpsr=%b stall=%b, required 1 %h %0d 1 %b 0",
                   n, wb_valid, wb_data, wb_dest_reg, wb_reg_we, cpsr, stall, exp_wb_data, dst, exp_cpsr);
        end
      end else begin
        delay = $urandom_range(0, 4);
        for (int i = 0; i <= delay; i++) begin
          checks++;
          if (stall !== 1'b1 || mem_req !== 1'b1 || mem_we !== !is_ld || mem_addr !== res[31:0] ||
              mem_wdata !== sdata || wb_valid !== 1'b0 || cpsr !== exp_cpsr) begin
            errors++;
            $display("FAIL rnd_busy[%0d.%0d]: stall=%b req=%b we=%b addr=%h wdata=%h wbv=%b cpsr=%b, required 1 1 %b %h %h 0 %b",
                     n, i, stall, mem_req, mem_we, mem_addr, mem_wdata, wb_valid, cpsr,
                     !is_ld, res[31:0], sdata, exp_cpsr);
          end
          drive_junk();
          mem_ready = (i == delay);
          mem_rdata = (i == delay) ? rdata : $urandom;
          tick();
        end
        exp_wb_data = is_ld ? rdata : 32'h0;
        checks++;
        if (wb_valid !== 1'b1 || wb_data !== exp_wb_data || wb_reg_we !== is_ld || (is_ld && wb_dest_reg !== dst) ||
            stall !== 1'b0 || mem_req !== 1'b0 || cpsr !== exp_cpsr || mem_fault !== 1'b0) begin
          errors++;
          $display("FAIL rnd_mem_done[%0d]: wbv=%b data=%h we=%b dst=%0d stall=%b req=%b cpsr=%b fault=%b, required 1 %h %b %0d 0 0 %b 0",
                   n, wb_valid, wb_data, wb_reg_we, wb_dest_reg, stall, mem_req, cpsr, mem_fault,
                   exp_wb_data, is_ld, dst, exp_cpsr);
        end
      end
      if ($urandom_range(0, 2) == 0) begin
        drive_none();
        ex_flags_we = 1'b1;
        ex_flags    = 4'($urandom_range(0, 15));
        mem_ready   = 1'b1;
        tick();
        checks++;
        if (wb_valid !== 1'b0 || wb_data !== exp_wb_data || cpsr !== exp_cpsr || stall !== 1'b0) begin
          errors++;
          $display("FAIL rnd_gap[%0d]: wbv=%b data=%h cpsr=%b stall=%b, required 0 %h %b 0",
                   n, wb_valid, wb_data, cpsr, stall, exp_wb_data, exp_cpsr);
        end
      end
    end
    drive_none();
    tick();
  endtask

  initial begin
    rst = 1'b1;
    drive_none();
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_reset_mid_busy();
`ifdef MEM_TIMEOUT_EN
    test_timeout();
`else
    test_long_wait();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
